// File: rtl/router_pkt_tx_if.sv
// Request, payload-stream and router-port signals of the router packet source.
// master: the packet source itself; slave: the traffic generator / router side.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] start_addr;
    logic [5:0] start_len;
    logic       ready;
    logic       bad_addr;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] data_in;
    logic       pkt_valid;
    logic       busy;
    logic       error;
    logic       done;
    logic       pkt_err;

    modport master (
        input  start, start_addr, start_len, pl_data, pl_valid, busy, error,
        output ready, bad_addr, pl_ready, data_in, pkt_valid, done, pkt_err
    );

    modport slave (
        output start, start_addr, start_len, pl_data, pl_valid, busy, error,
        input  ready, bad_addr, pl_ready, data_in, pkt_valid, done, pkt_err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a payload, then sends header, payload and parity
// to the router write port, stalling on busy and reporting the router error flag.
module router_pkt_tx #(
    parameter int unsigned MAX_LEN    = 63,
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic            clock,
    input  logic            resetn,
    router_pkt_tx_if.master bus
);

    localparam int unsigned     GapW    = $clog2(GAP_CYCLES + 1);
    localparam logic [6:0]      MaxLen  = 7'(MAX_LEN);
    localparam logic [GapW-1:0] GapInit = GapW'(GAP_CYCLES);

    typedef enum logic [2:0] {StIdle, StLoad, StHeader, StPayload, StParity, StGap} state_e;

    state_e          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      wr_cnt_q, wr_cnt_d;
    logic [5:0]      rd_cnt_q, rd_cnt_d;
    logic [7:0]      parity_q, parity_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            err_q, err_d;
    logic [7:0]      data_in_q, data_in_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            done_q, done_d;
    logic            pkt_err_q, pkt_err_d;
    logic            bad_addr_q, bad_addr_d;
    logic            buf_we;
    logic            hdr_enter;
    logic [7:0]      buffer_q [MAX_LEN];

    // Next-state, counters, parity/error tracking and the registered router byte
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        parity_d    = parity_q;
        gap_cnt_d   = gap_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        pkt_err_d   = 1'b0;
        bad_addr_d  = 1'b0;
        buf_we      = 1'b0;
        hdr_enter   = 1'b0;
        data_in_d   = 8'h00;
        pkt_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.start_addr == 2'd3 || {1'b0, bus.start_len} > MaxLen) begin
                        bad_addr_d = 1'b1;
                    end else begin
                        addr_d   = bus.start_addr;
                        len_d    = bus.start_len;
                        wr_cnt_d = 6'd0;
                        if (bus.start_len == 6'd0) begin
                            state_d   = StHeader;
                            hdr_enter = 1'b1;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
            end
            StLoad: begin
                if (bus.pl_valid) begin
                    buf_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (wr_cnt_d == len_q) begin
                        state_d   = StHeader;
                        hdr_enter = 1'b1;
                    end
                end
            end
            StHeader: begin
                if (!bus.busy) begin
                    state_d = (len_q == 6'd0) ? StParity : StPayload;
                end
            end
            StPayload: begin
                if (!bus.busy) begin
                    parity_d = parity_q ^ data_in_q;
                    rd_cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_d == len_q) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (!bus.busy) begin
                    state_d   = StGap;
                    gap_cnt_d = GapInit;
                    err_d     = err_q | bus.error;
                end
            end
            StGap: begin
                err_d = err_q | bus.error;
                if (gap_cnt_q == GapW'(1)) begin
                    state_d   = StIdle;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                    pkt_err_d = err_d;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Header entry restarts parity, the read pointer and the error latch
        if (hdr_enter) begin
            parity_d = {len_d, addr_d};
            rd_cnt_d = 6'd0;
            err_d    = 1'b0;
        end

        // The router byte follows the next state so it changes on the transition edge;
        // while busy the state and counters hold, so the byte holds too.
        case (state_d)
            StHeader: begin
                data_in_d   = {len_d, addr_d};
                pkt_valid_d = 1'b1;
            end
            StPayload: begin
                data_in_d   = buffer_q[rd_cnt_d];
                pkt_valid_d = 1'b1;
            end
            StParity: data_in_d = parity_d;
            default:  ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wr_cnt_q    <= 6'd0;
            rd_cnt_q    <= 6'd0;
            parity_q    <= 8'h00;
            gap_cnt_q   <= '0;
            err_q       <= 1'b0;
            data_in_q   <= 8'h00;
            pkt_valid_q <= 1'b0;
            done_q      <= 1'b0;
            pkt_err_q   <= 1'b0;
            bad_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            parity_q    <= parity_d;
            gap_cnt_q   <= gap_cnt_d;
            err_q       <= err_d;
            data_in_q   <= data_in_d;
            pkt_valid_q <= pkt_valid_d;
            done_q      <= done_d;
            pkt_err_q   <= pkt_err_d;
            bad_addr_q  <= bad_addr_d;
        end
    end

    // Payload buffer write port; contents need no reset
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buffer_q[wr_cnt_q] <= bus.pl_data;
        end
    end

    assign bus.ready     = (state_q == StIdle);
    assign bus.pl_ready  = (state_q == StLoad);
    assign bus.data_in   = data_in_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.done      = done_q;
    assign bus.pkt_err   = pkt_err_q;
    assign bus.bad_addr  = bad_addr_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: expected router bytes are queued when a packet
// is requested and popped by a monitor as the DUT transfers them.
module tb_router_pkt_tx;

    localparam int unsigned MaxLen = 63;
    localparam int unsigned Gap    = 3;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    router_pkt_tx_if u_if ();

    router_pkt_tx #(
        .MAX_LEN   (MaxLen),
        .GAP_CYCLES(Gap)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (u_if)
    );

    always #5 clock = ~clock;

    int         n_vec      = 0;
    int         n_err      = 0;
    int         cyc        = 0;
    int         parity_cyc = -100;
    logic       in_pkt     = 1'b0;
    logic [8:0] mon_exp;
    logic [8:0] exp_q[$];
    logic [7:0] pay[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: a byte transfers at the next posedge when busy is low
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            in_pkt = 1'b0;
        end else if (!u_if.busy && (u_if.pkt_valid || in_pkt)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_byte", 32'({u_if.pkt_valid, u_if.data_in}), 32'(mon_exp));
                if (!u_if.pkt_valid) begin
                    in_pkt     = 1'b0;
                    parity_cyc = cyc;
                end else begin
                    in_pkt = 1'b1;
                end
            end
        end
    end

    // Queue expected bytes, issue the request and stream the payload with one bubble
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] n, input string tag);
        logic [7:0] hdr;
        logic [7:0] par;
        hdr = {n, a};
        par = hdr;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back({1'b1, pay[i]});
            par = par ^ pay[i];
        end
        exp_q.push_back({1'b0, par});
        check({tag, "_ready"}, 32'(u_if.ready), 32'd1);
        u_if.start      = 1'b1;
        u_if.start_addr = a;
        u_if.start_len  = n;
        tick();
        u_if.start = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            if (i == 1) begin
                u_if.pl_valid = 1'b0;
                tick();
            end
            check({tag, "_pl_ready"}, 32'(u_if.pl_ready), 32'd1);
            u_if.pl_valid = 1'b1;
            u_if.pl_data  = pay[i];
            tick();
        end
        u_if.pl_valid = 1'b0;
        check({tag, "_hdr_now"}, 32'({u_if.pkt_valid, u_if.data_in}), 32'({1'b1, hdr}));
    endtask

    // Bounded wait for done; checks error flag, gap length and single-cycle pulse
    task automatic wait_done(input logic exp_err, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (u_if.done === 1'b1) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_pkt_err"}, 32'(u_if.pkt_err), 32'(exp_err));
            check({tag, "_gap_len"}, 32'(cyc - parity_cyc), 32'(Gap + 1));
            check({tag, "_ready_at_done"}, 32'(u_if.ready), 32'd1);
            @(negedge clock);
            check({tag, "_done_pulse"}, 32'(u_if.done), 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.start      = 1'b0;
        u_if.start_addr = 2'd0;
        u_if.start_len  = 6'd0;
        u_if.pl_data    = 8'h00;
        u_if.pl_valid   = 1'b0;
        u_if.busy       = 1'b0;
        u_if.error      = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 32'(u_if.ready), 32'd1);
        check("rst_pl_ready", 32'(u_if.pl_ready), 32'd0);
        check("rst_data_in", 32'(u_if.data_in), 32'h00);
        check("rst_pkt_valid", 32'(u_if.pkt_valid), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_pkt_err", 32'(u_if.pkt_err), 32'd0);
        check("rst_bad_addr", 32'(u_if.bad_addr), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic packet, no stall
        pay = '{8'hA5, 8'h3C, 8'h0F};
        send_pkt(2'd1, 6'd3, "t1");
        wait_done(1'b0, "t1");

        // Two busy cycles while the first payload byte is presented
        send_pkt(2'd1, 6'd3, "t2");
        tick();
        u_if.busy = 1'b1;
        check("t2_hold1", 32'({u_if.pkt_valid, u_if.data_in}), 32'h1A5);
        tick();
        check("t2_hold2", 32'({u_if.pkt_valid, u_if.data_in}), 32'h1A5);
        tick();
        u_if.busy = 1'b0;
        check("t2_hold3", 32'({u_if.pkt_valid, u_if.data_in}), 32'h1A5);
        wait_done(1'b0, "t2");

        // Zero-length packet; a start while busy with it is ignored
        pay.delete();
        send_pkt(2'd2, 6'd0, "t3");
        check("t3_no_pl_ready", 32'(u_if.pl_ready), 32'd0);
        u_if.start      = 1'b1;
        u_if.start_addr = 2'd3;
        u_if.start_len  = 6'd5;
        tick();
        u_if.start = 1'b0;
        check("t3_ignored_bad", 32'(u_if.bad_addr), 32'd0);
        check("t3_not_ready", 32'(u_if.ready), 32'd0);
        wait_done(1'b0, "t3");

        // Rejected request
        u_if.start      = 1'b1;
        u_if.start_addr = 2'd3;
        u_if.start_len  = 6'd5;
        tick();
        u_if.start = 1'b0;
        check("t4_bad_addr", 32'(u_if.bad_addr), 32'd1);
        check("t4_ready", 32'(u_if.ready), 32'd1);
        check("t4_pl_ready", 32'(u_if.pl_ready), 32'd0);
        tick();
        check("t4_bad_pulse", 32'(u_if.bad_addr), 32'd0);
        repeat (3) begin
            tick();
            check("t4_no_pkt_valid", 32'(u_if.pkt_valid), 32'd0);
        end

        // Router error during the gap, then a clean packet clears the latch
        pay = '{8'hA5, 8'h3C, 8'h0F};
        send_pkt(2'd1, 6'd3, "t5a");
        repeat (5) tick();
        u_if.error = 1'b1;
        tick();
        u_if.error = 1'b0;
        wait_done(1'b1, "t5a");
        pay = '{8'h11, 8'h22};
        send_pkt(2'd0, 6'd2, "t5b");
        wait_done(1'b0, "t5b");

        // Reset while the second payload byte is on the port
        pay = '{8'hA5, 8'h3C, 8'h0F};
        send_pkt(2'd1, 6'd3, "t6");
        tick();
        tick();
        check("t6_second_byte", 32'({u_if.pkt_valid, u_if.data_in}), 32'h13C);
        resetn = 1'b0;
        #1;
        check("t6_async_pv", 32'(u_if.pkt_valid), 32'd0);
        check("t6_async_data", 32'(u_if.data_in), 32'h00);
        repeat (2) begin
            tick();
            check("t6_no_done", 32'(u_if.done), 32'd0);
        end
        resetn = 1'b1;
        tick();
        check("t6_ready", 32'(u_if.ready), 32'd1);
        pay = '{8'h5A};
        send_pkt(2'd0, 6'd1, "t6b");
        wait_done(1'b0, "t6b");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
